// File: rtl/mic_control.sv
// I2S-style capture path: generates MCLK/SCK/LRCK for the codec and deserialises 16-bit stereo pairs.
// Optional peak-magnitude meters are built only when MIC_RX_PEAK_EN is defined.
module mic_control #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        audio_sdout,
    output logic        audio_mclk,
    output logic        audio_sck,
    output logic        audio_lrck,
    output logic [15:0] audio_out_left,
    output logic [15:0] audio_out_right,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        overrun,
    input  logic        overrun_clr
`ifdef MIC_RX_PEAK_EN
    ,
    output logic [15:0] peak_left,
    output logic [15:0] peak_right,
    input  logic        peak_clr
`endif
);

    // Sample point sits mid-bit, pushed back by the synchroniser latency.
    localparam logic [3:0] StrobePhase = 4'(7 + SYNC_STAGES);

    logic [8:0]             cnt;
    logic [SYNC_STAGES-1:0] sync;
    logic [15:0]            shift;
    logic [15:0]            shadow;
    logic [15:0]            shift_next;
    logic                   sync_out;
    logic                   strobe;
    logic                   left_done;
    logic                   frame_done;
    logic                   valid_d;
    logic                   overrun_d;

    assign audio_mclk = cnt[1];
    assign audio_sck  = cnt[3];
    assign audio_lrck = cnt[8];

    assign sync_out   = sync[SYNC_STAGES-1];
    assign shift_next = {shift[14:0], sync_out};
    assign strobe     = (cnt[3:0] == StrobePhase);
    assign left_done  = strobe && (cnt[8:4] == 5'd15);
    assign frame_done = strobe && (cnt[8:4] == 5'd31);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            sync <= '0;
        end else begin
            cnt     <= cnt + 9'd1;
            sync[0] <= audio_sdout;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync[i] <= sync[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift           <= '0;
            shadow          <= '0;
            audio_out_left  <= '0;
            audio_out_right <= '0;
        end else begin
            if (strobe) begin
                shift <= shift_next;
            end
            if (left_done) begin
                shadow <= shift_next;
            end
            // Both words load together so a consumer never sees a torn pair.
            if (frame_done) begin
                audio_out_left  <= shadow;
                audio_out_right <= shift_next;
            end
        end
    end

    always_comb begin
        valid_d   = sample_valid;
        overrun_d = overrun;
        if (frame_done) begin
            valid_d = 1'b1;
            if (sample_valid && !sample_ready) begin
                overrun_d = 1'b1;
            end else if (overrun_clr) begin
                overrun_d = 1'b0;
            end
        end else begin
            if (sample_valid && sample_ready) begin
                valid_d = 1'b0;
            end
            if (overrun_clr) begin
                overrun_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= valid_d;
            overrun      <= overrun_d;
        end
    end

`ifdef MIC_RX_PEAK_EN
    logic [15:0] mag_left;
    logic [15:0] mag_right;
    logic [15:0] peak_left_d;
    logic [15:0] peak_right_d;

    // Magnitude of a two's-complement word; -32768 saturates to 32767.
    function automatic logic [15:0] magnitude(input logic [15:0] s);
        if (s == 16'h8000) begin
            return 16'h7FFF;
        end else if (s[15]) begin
            return 16'(-s);
        end else begin
            return s;
        end
    endfunction

    assign mag_left  = magnitude(shadow);
    assign mag_right = magnitude(shift_next);

    always_comb begin
        peak_left_d  = peak_left;
        peak_right_d = peak_right;
        if (frame_done) begin
            if (peak_clr || (mag_left > peak_left)) begin
                peak_left_d = mag_left;
            end
            if (peak_clr || (mag_right > peak_right)) begin
                peak_right_d = mag_right;
            end
        end else if (peak_clr) begin
            peak_left_d  = '0;
            peak_right_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_left  <= '0;
            peak_right <= '0;
        end else begin
            peak_left  <= peak_left_d;
            peak_right <= peak_right_d;
        end
    end
`endif

endmodule

// File: tb/tb_mic_control.sv
// Randomised bench for mic_control: a frame-level codec/receiver model checked every cycle,
// plus directed scenarios with literal expectations (clocks, capture, back-pressure, reset).
module tb_mic_control;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        audio_sdout = 1'b0;
    logic        sample_ready = 1'b0;
    logic        overrun_clr = 1'b0;
    logic        audio_mclk, audio_sck, audio_lrck, sample_valid, overrun;
    logic [15:0] audio_out_left, audio_out_right;
`ifdef MIC_RX_PEAK_EN
    logic [15:0] peak_left, peak_right;
    logic        peak_clr = 1'b0;
`endif

    mic_control #(.SYNC_STAGES(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .audio_sdout     (audio_sdout),
        .audio_mclk      (audio_mclk),
        .audio_sck       (audio_sck),
        .audio_lrck      (audio_lrck),
        .audio_out_left  (audio_out_left),
        .audio_out_right (audio_out_right),
        .sample_valid    (sample_valid),
        .sample_ready    (sample_ready),
        .overrun         (overrun),
        .overrun_clr     (overrun_clr)
`ifdef MIC_RX_PEAK_EN
        ,
        .peak_left       (peak_left),
        .peak_right      (peak_right),
        .peak_clr        (peak_clr)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame position, words the codec sends this frame, receiver state.
    logic [8:0]  m_cnt = '0;
    logic        m_valid = 1'b0, m_ovr = 1'b0;
    logic [15:0] m_left = '0, m_right = '0, cur_l = '0, cur_r = '0;
    logic [15:0] q_l[$], q_r[$];
`ifdef MIC_RX_PEAK_EN
    logic [15:0] m_pl = '0, m_pr = '0;

    function automatic logic [15:0] mag(input logic [15:0] s);
        int v;
        v = $signed(s);
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return 16'(v);
    endfunction

    function automatic logic [15:0] max16(input logic [15:0] a, input logic [15:0] b);
        return (a > b) ? a : b;
    endfunction
`endif

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = '0; m_valid = 1'b0; m_ovr = 1'b0; m_left = '0; m_right = '0;
`ifdef MIC_RX_PEAK_EN
            m_pl = '0; m_pr = '0;
`endif
        end else begin
            if (m_cnt == 9'd505) begin
                m_left = cur_l;
                m_right = cur_r;
                if (m_valid && !sample_ready) m_ovr = 1'b1;
                else if (overrun_clr) m_ovr = 1'b0;
                m_valid = 1'b1;
`ifdef MIC_RX_PEAK_EN
                m_pl = peak_clr ? mag(cur_l) : max16(m_pl, mag(cur_l));
                m_pr = peak_clr ? mag(cur_r) : max16(m_pr, mag(cur_r));
`endif
            end else begin
                if (m_valid && sample_ready) m_valid = 1'b0;
                if (overrun_clr) m_ovr = 1'b0;
`ifdef MIC_RX_PEAK_EN
                if (peak_clr) begin m_pl = '0; m_pr = '0; end
`endif
            end
            m_cnt = m_cnt + 9'd1;
        end
    end

    // Codec: new words are chosen early in each frame; bit k is on the pin for cnt 16k..16k+15.
    always @(posedge clk) begin
        int idx;
        #1;
        if (m_cnt == 9'd1) begin
            if (q_l.size() > 0) begin
                cur_l = q_l.pop_front();
                cur_r = q_r.pop_front();
            end else begin
                cur_l = 16'($urandom);
                cur_r = 16'($urandom);
            end
        end
        idx = int'(m_cnt[8:4]);
        audio_sdout = (idx < 16) ? cur_l[15 - idx] : cur_r[31 - idx];
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("mclk", audio_mclk, m_cnt[1]);
            check("sck", audio_sck, m_cnt[3]);
            check("lrck", audio_lrck, m_cnt[8]);
            check("left", audio_out_left, m_left);
            check("right", audio_out_right, m_right);
            check("valid", sample_valid, m_valid);
            check("overrun", overrun, m_ovr);
`ifdef MIC_RX_PEAK_EN
            check("peak_left", peak_left, m_pl);
            check("peak_right", peak_right, m_pr);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cnt(input logic [8:0] n);
        for (int i = 0; i < 1100; i++) begin
            step();
            if (m_cnt == n) return;
        end
        check("wait_cnt_timeout", 32'd1, 32'd0);
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        q_l.push_back(l);
        q_r.push_back(r);
    endtask

    initial begin
        int mclk_r[$], sck_r[$], lrck_r[$];
        int sck_in_high;
        int n;
        logic pm, ps, pl;

        push(16'hA5C3, 16'h7F01);
        step();
        cmp_en = 1'b1;
        step();
        step();
        check("rst_valid", sample_valid, 1'b0);
        check("rst_left", audio_out_left, 16'h0000);
        check("rst_lrck", audio_lrck, 1'b0);
        rst = 1'b0;

        // Clock generation and first capture; cycle c has cnt == c mod 512.
        pm = audio_mclk; ps = audio_sck; pl = audio_lrck;
        sck_in_high = 0;
        for (int c = 1; c <= 1024; c++) begin
            step();
            if (audio_mclk && !pm) mclk_r.push_back(c);
            if (audio_sck && !ps) begin
                sck_r.push_back(c);
                if (c >= 256 && c < 512) sck_in_high++;
            end
            if (audio_lrck && !pl) lrck_r.push_back(c);
            pm = audio_mclk; ps = audio_sck; pl = audio_lrck;
            if (c == 505) check("valid_before_506", sample_valid, 1'b0);
            if (c == 506) begin
                check("valid_at_506", sample_valid, 1'b1);
                check("cap_left", audio_out_left, 16'hA5C3);
                check("cap_right", audio_out_right, 16'h7F01);
            end
        end
        check("mclk_period", 32'(mclk_r[1] - mclk_r[0]), 32'd4);
        check("sck_period", 32'(sck_r[1] - sck_r[0]), 32'd16);
        check("lrck_first_rise", 32'(lrck_r[0]), 32'd256);
        check("lrck_period", 32'(lrck_r[1] - lrck_r[0]), 32'd512);
        check("sck_per_phase", 32'(sck_in_high), 32'd16);
        check("ovr_after_two", overrun, 1'b1);

        overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
        check("ovr_cleared", overrun, 1'b0);
        sample_ready = 1'b1; step();
        check("valid_drained", sample_valid, 1'b0);

        // Back-pressure over three frames.
        wait_cnt(9'd510);
        push(16'h1234, 16'h8001); push(16'hFEDC, 16'h00FF); push(16'h5A5A, 16'hC3C3);
        sample_ready = 1'b0;
        wait_cnt(9'd506);
        check("bp1_ovr", overrun, 1'b0);
        check("bp1_left", audio_out_left, 16'h1234);
        wait_cnt(9'd506);
        check("bp2_ovr", overrun, 1'b1);
        wait_cnt(9'd506);
        check("bp3_left", audio_out_left, 16'h5A5A);
        check("bp3_right", audio_out_right, 16'hC3C3);
        overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
        check("bp_clr", overrun, 1'b0);
        wait_cnt(9'd505);
        overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
        check("set_beats_clr", overrun, 1'b1);

        // Ready arrives in the exact completion cycle.
        push(16'hBEEF, 16'h0042);
        overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
        wait_cnt(9'd505);
        sample_ready = 1'b1; step(); sample_ready = 1'b0;
        check("sim_valid", sample_valid, 1'b1);
        check("sim_ovr", overrun, 1'b0);
        check("sim_left", audio_out_left, 16'hBEEF);
        check("sim_right", audio_out_right, 16'h0042);

        // Mid-frame reset.
        wait_cnt(9'd300);
        rst = 1'b1; step(); rst = 1'b0;
        check("mrst_valid", sample_valid, 1'b0);
        check("mrst_left", audio_out_left, 16'h0000);
        check("mrst_right", audio_out_right, 16'h0000);
        check("mrst_sck", audio_sck, 1'b0);
        n = 0;
        for (int i = 0; i < 1024; i++) begin
            step();
            n++;
            if (sample_valid) break;
        end
        check("mrst_latency", 32'(n), 32'd506);

`ifdef MIC_RX_PEAK_EN
        sample_ready = 1'b1;
        peak_clr = 1'b1; step(); peak_clr = 1'b0;
        push(16'h0100, 16'h0000); push(16'h8000, 16'h0000);
        push(16'hFF00, 16'h0000); push(16'h0042, 16'h0000);
        wait_cnt(9'd506); check("peak1", peak_left, 16'h0100);
        wait_cnt(9'd506); check("peak2", peak_left, 16'h7FFF);
        wait_cnt(9'd506); check("peak3", peak_left, 16'h7FFF);
        wait_cnt(9'd505);
        peak_clr = 1'b1; step(); peak_clr = 1'b0;
        check("peak_clr_hit", peak_left, 16'h0042);
`endif

        // Random handshake traffic against the model.
        for (int i = 0; i < 2048; i++) begin
            sample_ready = 1'($urandom_range(0, 1));
            overrun_clr = ($urandom_range(0, 7) == 0);
`ifdef MIC_RX_PEAK_EN
            peak_clr = ($urandom_range(0, 63) == 0);
`endif
            step();
        end
        sample_ready = 1'b0;
        overrun_clr = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mic_control.md
# mic_control

I2S-style audio receiver: the capture-side counterpart of the speaker output path. It generates the master, bit, and word clocks for an external audio ADC/microphone codec, and deserialises the codec's serial data into 16-bit left/right samples. Each completed stereo pair is presented to downstream logic through a valid/ready handshake, with a sticky overrun flag. Framing matches the playback path: 32 bit-clocks per frame, MSB first, left slot while LRCK is low, no one-bit delay.

## Interface
- SYNC_STAGES, 2, flops in the audio_sdout synchroniser; legal range 1–3.

- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous, active-high reset.
- audio_sdout  in  1  serial data from codec.
- audio_mclk  out  1  master clock = clk/4.
- audio_sck  out  1  bit clock = clk/16.
- audio_lrck  out  1  word clock = clk/512; low = left slot.
- audio_out_left  out  16  last captured left sample, two's complement.
- audio_out_right  out  16  last captured right sample, two's complement.
- sample_valid  out  1  stereo pair available.
- sample_ready  in  1  consumer accepts pair.
- overrun  out  1  sticky: a pair was overwritten before acceptance.
- overrun_clr  in  1  clears overrun.
- peak_left, peak_right  out  16  peak magnitude (only with MIC_RX_PEAK_EN).
- peak_clr  in  1  clears peaks (only with MIC_RX_PEAK_EN).

## Operation
- One free-running 9-bit counter cnt increments every clk and wraps 511→0. It drives audio_mclk = cnt[1], audio_sck = cnt[3], audio_lrck = cnt[8]. All three are registered, glitch-free, and phase-locked to each other.
- The bit index within the frame is cnt[8:4]: 0–15 is the left slot (MSB…LSB), 16–31 is the right slot.
- audio_sdout passes through SYNC_STAGES flops.
- The shift strobe fires in cycles where cnt[3:0] == 7 + SYNC_STAGES. On each strobe, the synchroniser output is shifted into a 16-bit shift register, LSB-in.
- Left word: on the strobe of bit index 15, the shift register is copied into a left shadow register.
- Right word: on the strobe of bit index 31, the frame is complete.
  - audio_out_left is loaded from the left shadow.
  - audio_out_right is loaded from the shift register.
  - Both outputs update in the same cycle, so the pair is always coherent.
- Handshake:
  - A transfer occurs when sample_valid && sample_ready.
  - sample_valid sets on frame completion and clears on transfer.
  - If a completion coincides with a transfer, the new pair loads and sample_valid stays 1. No overrun is flagged.
  - If a completion occurs while sample_valid = 1 and there is no transfer, the new pair overwrites the old one, sample_valid stays 1, and overrun is set.
  - overrun clears on overrun_clr. If set and clear occur in the same cycle, set wins.
- Outputs hold their value between completions.

## Timing
- During reset: cnt = 0, synchroniser = 0, shift and shadow registers = 0, and every output = 0.
- cnt reads 0 in the first cycle after rst falls.
- Frame period: 512 clk. Left completes at cnt = 240 + 7 + SYNC_STAGES. Right completes at cnt = 496 + 7 + SYNC_STAGES (505 at the default).
- With SYNC_STAGES = 2, the outputs and sample_valid update in the cycle where cnt = 506.
- The first valid pair appears at cnt = 506 of the first frame after reset. Its contents are whatever was on audio_sdout during that frame.
- Latency from the pin's LSB-of-right sample point to sample_valid is SYNC_STAGES + 1 clk.
- sample_ready has a combinational effect only on the next-state logic. There is no combinational path from inputs to outputs.
- Reset asserted mid-frame aborts the partial frame: no valid is produced, and capture restarts at bit index 0.

## Configuration
- MIC_RX_PEAK_EN defined:
  - peak_left, peak_right, and peak_clr exist.
  - On each frame completion, peak_x <= max(peak_x, |sample_x|). |−32768| saturates to 32767.
  - peak_clr sets peaks to 0. If peak_clr coincides with a completion, peak_x <= |sample_x|.
  - Reset value is 0.
- MIC_RX_PEAK_EN undefined: the three ports and all peak logic are absent. Nothing else changes.

## Test plan
- Clock generation: release reset, run 1024 clk. Check mclk period 4, sck period 16, lrck period 512, lrck rising at cnt = 256, and 16 sck rising edges per lrck phase.
- Capture: codec model drives 16'hA5C3 left and 16'h7F01 right, changing on sck falling edges. Expect audio_out_left = A5C3, audio_out_right = 7F01, and sample_valid rising at cnt = 506.
- Back-pressure: hold sample_ready = 0 for 3 frames with distinct data. Expect overrun = 1 after the second completion and the outputs holding the third pair. Pulse overrun_clr → overrun = 0. Assert overrun_clr in the same cycle as a fresh overrun → overrun = 1.
- Simultaneous events: raise sample_ready in the exact completion cycle with sample_valid = 1. Expect the new pair loaded, sample_valid = 1, overrun = 0.
- Reset mid-frame: assert rst at cnt = 300 for 1 clk. Expect all outputs 0, cnt = 0 next cycle, and the next valid exactly 506 cycles later.
- Peak (MIC_RX_PEAK_EN): left sequence 16'h0100, 16'h8000, 16'hFF00. Expect peak_left 0100 → 7FFF → 7FFF. Pulse peak_clr coincident with a 16'h0042 completion → peak_left = 0042.
